// File: rtl/text_term_buffer.sv
// -----------------------------------------------------------------------------
// text_term_buffer
// Character terminal buffer sitting between a UART receiver and a VGA text
// renderer. Bytes arrive over a valid/ready handshake and are placed into a
// COLS x ROWS character RAM at the cursor. CR/LF, backspace and line wrap are
// handled here. At the bottom row the screen either scrolls (rotating a base
// row offset) or the cursor wraps to the top. A registered read port serves
// the text generator using logical rows (0 = top of screen).
//
// Ports
//   clk       system clock, all logic on posedge
//   reset     synchronous active-high reset (restarts the full-screen clear)
//   in_valid  byte offered
//   in_ready  byte accepted when in_valid && in_ready
//   in_data   received byte
//   clr       clear-screen request (one-cycle pulse)
//   rd_col    display read column
//   rd_row    display read row (logical)
//   rd_char   character at (rd_row, rd_col), one cycle after the address
//   cur_col   cursor column
//   cur_row   cursor row (logical)
//   busy      high while any clear is in progress
// -----------------------------------------------------------------------------
module text_term_buffer #(
    parameter int         COLS       = 32,
    parameter int         ROWS       = 4,
    parameter bit         SCROLL     = 1'b1,
    parameter logic [7:0] CLEAR_CHAR = 8'h20,
    parameter int         COL_W      = $clog2(COLS),
    parameter int         ROW_W      = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             clr,
    input  logic [COL_W-1:0] rd_col,
    input  logic [ROW_W-1:0] rd_row,
    output logic [7:0]       rd_char,
    output logic [COL_W-1:0] cur_col,
    output logic [ROW_W-1:0] cur_row,
    output logic             busy
);
    localparam int CELLS = ROWS * COLS;
    localparam int AW    = $clog2(CELLS);

    localparam logic [COL_W-1:0] ZERO_COL = COL_W'(0);
    localparam logic [COL_W-1:0] ONE_COL  = COL_W'(1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ZERO_ROW = ROW_W'(0);
    localparam logic [ROW_W-1:0] ONE_ROW  = ROW_W'(1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]   ROWS_EXT = (ROW_W+1)'(ROWS);

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        CLEAR_ROW = 2'd2
    } state_t;

    state_t           r_state;
    logic [COL_W-1:0] r_clr_col;
    logic [ROW_W-1:0] r_clr_row;   // physical row being cleared
    logic [ROW_W-1:0] r_base;      // physical row shown as logical row 0
    logic [COL_W-1:0] r_cur_col;
    logic [ROW_W-1:0] r_cur_row;
    logic [7:0]       r_rd_char;
    logic [7:0]       r_mem [CELLS];

    logic             w_accept;
    logic             w_is_nl;
    logic             w_is_bs;
    logic             w_is_print;
    logic             w_adv;
    logic [ROW_W-1:0] w_cur_prow;
    logic [ROW_W-1:0] w_next_base;
    logic [AW-1:0]    w_rd_addr;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [7:0]       w_wdata;

    // Logical to physical row: compare-subtract so ROWS need not be a power of two.
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] lrow,
                                                  input logic [ROW_W-1:0] base);
        logic [ROW_W:0] sum;
        sum = {1'b0, lrow} + {1'b0, base};
        sum = (sum >= ROWS_EXT) ? (sum - ROWS_EXT) : sum;
        return sum[ROW_W-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                input logic [COL_W-1:0] col);
        return AW'(prow) * AW'(COLS) + AW'(col);
    endfunction

    // reset is folded in so nothing is taken while the block is being reset
    assign in_ready    = (r_state == IDLE) && !clr && !reset;
    assign busy        = (r_state != IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_is_nl     = (in_data == 8'h0D) || (in_data == 8'h0A);
    assign w_is_bs     = (in_data == 8'h08);
    assign w_is_print  = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign w_adv       = w_accept && (w_is_nl || (w_is_print && (r_cur_col == LAST_COL)));
    assign w_cur_prow  = phys_row(r_cur_row, r_base);
    assign w_next_base = (r_base == LAST_ROW) ? ZERO_ROW : (r_base + ONE_ROW);
    assign w_rd_addr   = cell_addr(phys_row(rd_row, r_base), rd_col);

    assign rd_char = r_rd_char;
    assign cur_col = r_cur_col;
    assign cur_row = r_cur_row;

    // Control FSM: clear sequencing, cursor and scroll base.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_state   <= CLEAR_ALL;
            r_clr_col <= ZERO_COL;
            r_clr_row <= ZERO_ROW;
            r_base    <= ZERO_ROW;
            r_cur_col <= ZERO_COL;
            r_cur_row <= ZERO_ROW;
        end else begin
            case (r_state)
                CLEAR_ALL: begin
                    if (r_clr_col == LAST_COL) begin
                        r_clr_col <= ZERO_COL;
                        if (r_clr_row == LAST_ROW) begin
                            r_clr_row <= ZERO_ROW;
                            r_state   <= IDLE;
                        end else begin
                            r_clr_row <= r_clr_row + ONE_ROW;
                        end
                    end else begin
                        r_clr_col <= r_clr_col + ONE_COL;
                    end
                end
                CLEAR_ROW: begin
                    if (r_clr_col == LAST_COL) begin
                        r_clr_col <= ZERO_COL;
                        r_state   <= IDLE;
                    end else begin
                        r_clr_col <= r_clr_col + ONE_COL;
                    end
                end
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_nl) begin
                            r_cur_col <= ZERO_COL;
                        end else if (w_is_bs) begin
                            if (r_cur_col != ZERO_COL) begin
                                r_cur_col <= r_cur_col - ONE_COL;
                            end
                        end else if (w_is_print) begin
                            r_cur_col <= (r_cur_col == LAST_COL) ? ZERO_COL : (r_cur_col + ONE_COL);
                        end
                        if (w_adv) begin
                            if (r_cur_row != LAST_ROW) begin
                                r_cur_row <= r_cur_row + ONE_ROW;
                            end else begin
                                // Either way the row to clear is the current base:
                                // scrolling makes the old top the new bottom, and
                                // wrapping clears logical row 0.
                                if (SCROLL) begin
                                    r_base <= w_next_base;
                                end else begin
                                    r_cur_row <= ZERO_ROW;
                                end
                                r_clr_row <= r_base;
                                r_clr_col <= ZERO_COL;
                                r_state   <= CLEAR_ROW;
                            end
                        end
                    end
                end
                default: begin
                    r_state   <= CLEAR_ALL;
                    r_clr_col <= ZERO_COL;
                    r_clr_row <= ZERO_ROW;
                end
            endcase
        end
    end

    // Single RAM write port: clear sequencer or accepted byte.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = cell_addr(ZERO_ROW, ZERO_COL);
        w_wdata = CLEAR_CHAR;
        case (r_state)
            CLEAR_ALL, CLEAR_ROW: begin
                w_we    = !reset;
                w_waddr = cell_addr(r_clr_row, r_clr_col);
            end
            IDLE: begin
                if (w_accept && w_is_print) begin
                    w_we    = 1'b1;
                    w_waddr = cell_addr(w_cur_prow, r_cur_col);
                    w_wdata = in_data;
                end else if (w_accept && w_is_bs && (r_cur_col != ZERO_COL)) begin
                    w_we    = 1'b1;
                    w_waddr = cell_addr(w_cur_prow, r_cur_col - ONE_COL);
                end else begin
                    w_we = 1'b0;
                end
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // Character RAM write.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Registered read port; out-of-range addresses return the fill byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_char <= 8'h00;
        end else if ((rd_col <= LAST_COL) && (rd_row <= LAST_ROW)) begin
            r_rd_char <= r_mem[w_rd_addr];
        end else begin
            r_rd_char <= CLEAR_CHAR;
        end
    end

endmodule

// File: tb/tb_text_term_buffer.sv
module tb_text_term_buffer;
    localparam int COLS  = 32;
    localparam int ROWS  = 4;
    localparam int COL_W = 5;
    localparam int ROW_W = 2;
    localparam int CELLS = ROWS * COLS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             clr;
    logic [1:0]       iv;
    logic [7:0]       in_data;
    logic [COL_W-1:0] rd_col;
    logic [ROW_W-1:0] rd_row;

    logic             rdy0, rdy1, busy0, busy1;
    logic [7:0]       rc0, rc1;
    logic [COL_W-1:0] cc0, cc1;
    logic [ROW_W-1:0] cr0, cr1;

    // instance 0 scrolls, instance 1 wraps to the top
    text_term_buffer #(.COLS(COLS), .ROWS(ROWS), .SCROLL(1'b1), .CLEAR_CHAR(8'h20)) u_scroll (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy0), .in_data(in_data),
        .clr(clr), .rd_col(rd_col), .rd_row(rd_row), .rd_char(rc0),
        .cur_col(cc0), .cur_row(cr0), .busy(busy0));

    text_term_buffer #(.COLS(COLS), .ROWS(ROWS), .SCROLL(1'b0), .CLEAR_CHAR(8'h20)) u_wrap (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy1), .in_data(in_data),
        .clr(clr), .rd_col(rd_col), .rd_row(rd_row), .rd_char(rc1),
        .cur_col(cc1), .cur_row(cr1), .busy(busy1));

    int checks = 0;
    int errors = 0;

    // Reference model: the screen as seen logically (row 0 = top)
    logic [7:0] scr [2][ROWS][COLS];
    int         m_row  [2];
    int         m_col  [2];
    int         m_busy [2];
    logic [1:0] acc_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_screen(input int k);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[k][r][c] = 8'h20;
        m_row[k] = 0;
        m_col[k] = 0;
    endtask

    task automatic apply_byte(input int k, input logic [7:0] b);
        bit adv;
        adv = 1'b0;
        if (b == 8'h0D || b == 8'h0A) begin
            m_col[k] = 0;
            adv = 1'b1;
        end else if (b == 8'h08) begin
            if (m_col[k] > 0) begin
                m_col[k]--;
                scr[k][m_row[k]][m_col[k]] = 8'h20;
            end
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            scr[k][m_row[k]][m_col[k]] = b;
            if (m_col[k] == COLS - 1) begin
                m_col[k] = 0;
                adv = 1'b1;
            end else begin
                m_col[k]++;
            end
        end
        if (adv) begin
            if (m_row[k] < ROWS - 1) begin
                m_row[k]++;
            end else begin
                if (k == 0) begin
                    for (int r = 0; r < ROWS - 1; r++)
                        for (int c = 0; c < COLS; c++)
                            scr[k][r][c] = scr[k][r+1][c];
                    for (int c = 0; c < COLS; c++) scr[k][ROWS-1][c] = 8'h20;
                end else begin
                    m_row[k] = 0;
                    for (int c = 0; c < COLS; c++) scr[k][0][c] = 8'h20;
                end
                m_busy[k] = COLS;
            end
        end
    endtask

    // One clock: check handshake before the edge, then model and outputs after it
    task automatic cycle();
        logic [7:0] exp_rd [2];
        logic       chk_rd [2];
        logic       rdy    [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            rdy[k]    = (m_busy[k] == 0) && !clr && !reset;
            chk_rd[k] = reset || (m_busy[k] == 0);
            exp_rd[k] = reset ? 8'h00 : scr[k][rd_row][rd_col];
        end
        check("in_ready_scroll", rdy0, rdy[0]);
        check("in_ready_wrap", rdy1, rdy[1]);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            acc_last[k] = rdy[k] && iv[k];
            if (reset || clr) begin
                clear_screen(k);
                m_busy[k] = CELLS;
            end else if (m_busy[k] > 0) begin
                m_busy[k]--;
            end else if (iv[k]) begin
                apply_byte(k, in_data);
            end
        end
        check("busy_scroll", busy0, m_busy[0] != 0);
        check("busy_wrap", busy1, m_busy[1] != 0);
        check("cur_col_scroll", cc0, m_col[0]);
        check("cur_row_scroll", cr0, m_row[0]);
        check("cur_col_wrap", cc1, m_col[1]);
        check("cur_row_wrap", cr1, m_row[1]);
        if (chk_rd[0]) check("rd_char_scroll", rc0, exp_rd[0]);
        if (chk_rd[1]) check("rd_char_wrap", rc1, exp_rd[1]);
    endtask

    task automatic send(input logic [7:0] b);
        logic [1:0] pend;
        int n;
        pend = 2'b11;
        n = 0;
        in_data = b;
        while (pend != 2'b00 && n < 400) begin
            iv = pend;
            rd_row = ROW_W'($urandom_range(ROWS - 1));
            rd_col = COL_W'($urandom_range(COLS - 1));
            cycle();
            pend = pend & ~acc_last;
            n++;
        end
        iv = 2'b00;
        check("send_accepted", pend, 2'b00);
    endtask

    task automatic wait_idle(input string tag, input int exp);
        int n;
        n = 0;
        while ((busy0 === 1'b1 || busy1 === 1'b1) && n < 2 * CELLS) begin
            cycle();
            n++;
        end
        check(tag, n, exp);
    endtask

    task automatic read_cell(input int r, input int c);
        rd_row = ROW_W'(r);
        rd_col = COL_W'(c);
        cycle();
    endtask

    task automatic sweep();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                read_cell(r, c);
    endtask

    task automatic send_row_tag(input int r);
        send(8'h52);
        send(8'h4F);
        send(8'h57);
        send(8'(8'h30 + r));
        send(8'h0D);
    endtask

    initial begin
        logic [7:0] b;
        int sel;
        reset = 1'b1; clr = 1'b0; iv = 2'b00; in_data = 8'h00;
        rd_row = '0; rd_col = '0; acc_last = 2'b00;
        for (int k = 0; k < 2; k++) begin
            clear_screen(k);
            m_busy[k] = CELLS;
        end

        // reset and the power-up clear
        repeat (3) cycle();
        check("reset_rd_char", rc0, 8'h00);
        check("reset_busy", busy0, 1'b1);
        check("reset_in_ready", rdy0, 1'b0);
        reset = 1'b0;
        wait_idle("reset_clear_len", CELLS);
        check("reset_cur", {cr0, cc0}, 7'd0);
        sweep();

        // "AB"
        send(8'h41);
        send(8'h42);
        check("ab_cur_col", cc0, 5'd2);
        check("ab_cur_row", cr0, 2'd0);
        read_cell(0, 0);
        check("ab_cell0", rc0, 8'h41);
        read_cell(0, 1);
        check("ab_cell1", rc1, 8'h42);

        // fill row 0 to force the wrap to row 1
        for (int i = 0; i < 30; i++) send(8'(8'h61 + i));
        check("wrap_cur_row", cr0, 2'd1);
        check("wrap_cur_col", cc0, 5'd0);

        // tag rows 1..3; the last CR is issued on the bottom row
        for (int r = 1; r < ROWS; r++) send_row_tag(r);
        wait_idle("row_clear_len", COLS);
        check("scroll_cur_row", cr0, 2'd3);
        check("scroll_cur_col", cc0, 5'd0);
        check("topwrap_cur_row", cr1, 2'd0);
        check("topwrap_cur_col", cc1, 5'd0);
        read_cell(0, 3);
        check("scroll_old_row1_top", rc0, 8'h31);
        check("topwrap_row0_cleared", rc1, 8'h20);
        read_cell(1, 3);
        check("topwrap_row1_kept", rc1, 8'h31);
        read_cell(3, 0);
        check("scroll_bottom_cleared", rc0, 8'h20);
        check("topwrap_row3_kept", rc1, 8'h52);
        sweep();

        // clr with a byte offered in the same cycle
        clr = 1'b1; iv = 2'b11; in_data = 8'h51;
        cycle();
        check("clr_blocks_byte", acc_last, 2'b00);
        clr = 1'b0; iv = 2'b00;
        wait_idle("clr_clear_len", CELLS);
        check("clr_cur", {cr1, cc1}, 7'd0);

        // backspace / control bytes
        send(8'h48); send(8'h45); send(8'h4C); send(8'h4C); send(8'h4F);
        send(8'h08);
        check("bs_cur_col", cc0, 5'd4);
        read_cell(0, 4);
        check("bs_cell_cleared", rc0, 8'h20);
        read_cell(0, 3);
        check("bs_cell_kept", rc0, 8'h4C);
        repeat (4) send(8'h08);
        send(8'h08);
        check("bs_col0_noop", cc0, 5'd0);
        send(8'h07);
        check("bel_ignored", {cr0, cc0}, 7'd0);

        // randomized stream against the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(99) == 0) begin
                clr = 1'b1;
                cycle();
                clr = 1'b0;
            end
            sel = $urandom_range(99);
            if (sel < 55)      b = 8'($urandom_range(8'h7E, 8'h20));
            else if (sel < 65) b = 8'h0D;
            else if (sel < 70) b = 8'h0A;
            else if (sel < 82) b = 8'h08;
            else if (sel < 90) b = 8'h1B;
            else               b = 8'($urandom_range(8'hFF, 8'h7F));
            send(b);
        end
        repeat (2 * CELLS) cycle();
        sweep();

        // reset in the middle of a row clear
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        wait_idle("clr2_clear_len", CELLS);
        for (int r = 0; r < ROWS; r++) send(8'h0A);
        repeat (5) cycle();
        check("midclear_busy", busy0, 1'b1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        wait_idle("reset_midclear_len", CELLS);
        check("reset_midclear_cur", {cr0, cc0}, 7'd0);
        sweep();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
